ocm_port_ctrl: RTL and testbench
================================

// Module: ocm_port_ctrl
// PURPOSE
//  Initiator side of the on-chip SRAM pin protocol: converts a valid/ready request stream into
//  the active-low CEN/WEN/A/D pins of one sys_sram port and returns read data through valid/ready.
//  Read data is captured from Q into a credit-protected response FIFO, so a stalled consumer never
//  drops data. Sits between the core's memory-side masters (e.g. cache refill) and sys_sram.
// PARAMETERS
//  AW        12   SRAM address width (word = DW bits)
//  DW        128  data width
//  RSP_DEPTH 4    response FIFO entries; power of two, >= 2; >= 3 gives 1 read/cycle throughput
// PORTS
//  sys_clk    in  1          clock; all state updates on rising edge
//  sys_rst    in  1          asynchronous, active-high reset
//  req_valid  in  1          request valid
//  req_ready  out 1          request accepted when req_valid & req_ready ("fire")
//  req_write  in  1          1 = write, 0 = read
//  req_addr   in  AW         word address
//  req_wdata  in  DW         write data (ignored for reads)
//  rsp_valid  out 1          read data valid
//  rsp_ready  in  1          consumer accepts read data
//  rsp_rdata  out DW         read data, FIFO head
//  idle       out 1          no read in flight and FIFO empty
//  CEN        out 1          SRAM chip enable, active low
//  WEN        out 1          SRAM write enable, active low
//  A          out AW         SRAM address
//  D          out DW         SRAM write data
//  Q          in  DW         SRAM read data, valid the cycle after a read access
// BEHAVIOUR
//  - Reset (async, held while sys_rst=1): FIFO count/pointers=0, rd_pend=0; outputs req_ready=0,
//    rsp_valid=0, rsp_rdata=0, idle=1, CEN=1, WEN=1. A/D follow request inputs (don't care).
//  - Credit: req_ready = !sys_rst & (req_write | (count + rd_pend < RSP_DEPTH)). Writes never
//    stall. Same-cycle pop does NOT add credit (req_ready independent of rsp_ready).
//  - SRAM pins are combinational from the request: CEN = !fire; WEN = !(fire & req_write);
//    A = req_addr; D = req_wdata. No SRAM access without fire; exactly one access per fire.
//  - Read timing: fire in cycle T -> rd_pend=1 in T+1 -> Q written into FIFO at end of T+1 ->
//    rsp_valid=1 from T+2. Fixed latency 2, no bypass. rd_pend clears if no read fired in T+1.
//  - Write: fire in T writes SRAM at end of T; no response generated.
//  - FIFO: push = rd_pend, pop = rsp_valid & rsp_ready; simultaneous push+pop keeps count,
//    both pointers advance; pointers wrap modulo RSP_DEPTH. Push when full cannot occur (credit);
//    bench asserts it. rsp_rdata = head entry when rsp_valid, else 0.
//  - Order: responses returned strictly in read-issue order; a write issued after a read to the
//    same address does not affect that read's data (read launched first).
//  - rsp_valid, once 1, stays 1 with stable rsp_rdata until popped.
//  - idle = (count == 0) & !rd_pend.
//  - Reset mid-operation: in-flight read and all buffered data discarded; Q ignored after reset;
//    first access after deassertion behaves as from a clean start.
// TESTING
//  1. Write 0x..AA (DW pattern) to addr 0x010, read 0x010 -> CEN=0,WEN=0 once; then
//     CEN=0,WEN=1; rsp_valid exactly 2 cycles after read fire, rsp_rdata=0x..AA.
//  2. 8 back-to-back reads addr 0..7, rsp_ready=1, RSP_DEPTH=4 -> req_ready stays 1, 8 responses
//     on consecutive cycles, in address order, idle=1 afterwards.
//  3. rsp_ready=0, issue 6 reads -> exactly 4 accepted, req_ready=0 after 4th; writes still fire;
//     release rsp_ready -> 4 ordered responses, then remaining 2 reads accepted.
//  4. Read addr 5 fire at T, write addr 5 fire at T+1 -> response carries old value; later read
//     returns new value.
//  5. Assert sys_rst asynchronously with 2 entries buffered and 1 read pending -> immediately
//     rsp_valid=0, CEN=1, idle=1; after release, read returns correct data, no stale response.

Source files
------------

// File: rtl/ocm_port_ctrl.sv
// ocm_port_ctrl: initiator for one sys_sram port.
// Converts a valid/ready request stream into active-low SRAM pins and
// returns read data through a credit-protected response FIFO.
//
// Handshake semantics (both streams): a transfer happens in a cycle where
// valid & ready are both 1 at the rising edge. req_ready never depends on
// req_valid. rsp_valid never depends on rsp_ready. Once rsp_valid is 1 it
// holds, with rsp_rdata stable, until the transfer happens.
module ocm_port_ctrl #(
  parameter int AW        = 12,
  parameter int DW        = 128,
  parameter int RSP_DEPTH = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          idle,
  output logic          CEN,
  output logic          WEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  input  logic [DW-1:0] Q
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int UW = CW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] mem_q [RSP_DEPTH];
  logic [DW-1:0] mem_d [RSP_DEPTH];

  logic [UW-1:0] used;
  logic          fire;
  logic          push;
  logic          pop;

  // Credit check, SRAM pin generation and response-side outputs.
  // A read is only accepted if the FIFO is guaranteed a free slot for it
  // once its data returns; a pop in the same cycle does not count.
  always_comb begin
    used      = {1'b0, count_q} + {{CW{1'b0}}, rd_pend_q};
    req_ready = !sys_rst & (req_write | (used < UW'(RSP_DEPTH)));
    fire      = req_valid & req_ready;
    CEN       = !fire;
    WEN       = !(fire & req_write);
    A         = req_addr;
    D         = req_wdata;
    rsp_valid = (count_q != '0);
    rsp_rdata = rsp_valid ? mem_q[rd_ptr_q] : '0;
    idle      = (count_q == '0) & !rd_pend_q;
    push      = rd_pend_q;
    pop       = rsp_valid & rsp_ready;
  end

  // Next-state: Q is captured the cycle after a read access; pointers
  // wrap naturally because the depth is a power of two.
  always_comb begin
    rd_pend_d = fire & !req_write;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = Q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards the in-flight read and all buffered data.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_pend_q <= rd_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ocm_port_ctrl.sv
// Bench for ocm_port_ctrl: SRAM device model on the pins, a transaction
// level reference (outstanding-read queue with due cycles plus a shadow
// memory), a per-cycle compare process, and directed plus random stimulus.
module tb_ocm_port_ctrl;

  localparam int AW        = 12;
  localparam int DW        = 128;
  localparam int RSP_DEPTH = 4;
  localparam int NWORDS    = 1 << AW;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          idle;
  logic          CEN;
  logic          WEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] Q = '0;

  ocm_port_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(RSP_DEPTH)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .idle     (idle),
    .CEN      (CEN),
    .WEN      (WEN),
    .A        (A),
    .D        (D),
    .Q        (Q)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pre_val(input int a);
    return {32'(a) * 32'h9E37_79B1, ~32'(a), 32'hC0DE_0000 | 32'(a), 32'(a) ^ 32'h5A5A_5A5A};
  endfunction

  // ---------------- SRAM device model (pins only) ----------------
  logic [DW-1:0] sram [NWORDS];
  logic          p_cen = 1'b1;
  logic          p_wen = 1'b1;
  logic [AW-1:0] p_a   = '0;
  logic [DW-1:0] p_d   = '0;

  always @(negedge sys_clk) begin
    p_cen = CEN;
    p_wen = WEN;
    p_a   = A;
    p_d   = D;
  end

  // Q carries the read word the cycle after a read, noise otherwise.
  always @(posedge sys_clk) begin
    if (!p_cen && !p_wen) sram[p_a] = p_d;
    if (!p_cen && p_wen) Q <= sram[p_a];
    else Q <= {$urandom, $urandom, $urandom, $urandom};
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [NWORDS];
  logic [DW-1:0] exp_q [$];
  int            due_q [$];

  always @(negedge sys_clk) begin
    int            outst;
    logic          e_ready;
    logic          e_fire;
    logic          hv;
    logic [DW-1:0] e_data;
    if (sys_rst) begin
      exp_q.delete();
      due_q.delete();
      chk("rst_req_ready", DW'(req_ready), DW'(0));
      chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_idle", DW'(idle), DW'(1));
      chk("rst_cen", DW'(CEN), DW'(1));
      chk("rst_wen", DW'(WEN), DW'(1));
    end else begin
      outst   = exp_q.size();
      e_ready = req_write | (outst < RSP_DEPTH);
      e_fire  = req_valid & e_ready;
      hv      = (outst > 0) && (due_q[0] <= cyc);
      e_data  = hv ? exp_q[0] : '0;
      chk("req_ready", DW'(req_ready), DW'(e_ready));
      chk("cen", DW'(CEN), DW'(!e_fire));
      chk("wen", DW'(WEN), DW'(!(e_fire & req_write)));
      chk("addr_pin", DW'(A), DW'(req_addr));
      chk("data_pin", D, req_wdata);
      chk("rsp_valid", DW'(rsp_valid), DW'(hv));
      chk("rsp_rdata", rsp_rdata, e_data);
      chk("idle", DW'(idle), DW'(outst == 0));
      if (req_valid && !req_write && req_ready)
        chk("credit_room", DW'(outst < RSP_DEPTH), DW'(1));
      if (hv && rsp_ready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (e_fire) begin
        if (req_write) begin
          ref_mem[req_addr] = req_wdata;
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
          due_q.push_back(cyc + 2);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic go(input logic v, input logic w, input int a, input logic [DW-1:0] d,
                    input logic rr);
    @(posedge sys_clk);
    #1;
    req_valid = v;
    req_write = w;
    req_addr  = AW'(a);
    req_wdata = d;
    rsp_ready = rr;
    @(negedge sys_clk);
  endtask

  logic [DW-1:0] pat_aa;
  logic [DW-1:0] newv;
  int            acc;

  initial begin
    pat_aa = {16{8'hAA}};
    newv   = {4{32'hFEED_F00D}};
    for (int i = 0; i < NWORDS; i++) begin
      sram[i]    = pre_val(i);
      ref_mem[i] = pre_val(i);
    end

    // Reset
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("lit_idle_after_reset", DW'(idle), DW'(1));
    chk("lit_rdy_after_reset", DW'(req_ready), DW'(1));

    // 1: write then read-back with latency 2
    go(1, 1, 'h010, pat_aa, 1);
    chk("lit_t1_wr_cen", DW'(CEN), DW'(0));
    chk("lit_t1_wr_wen", DW'(WEN), DW'(0));
    go(1, 0, 'h010, '0, 1);
    chk("lit_t1_rd_cen", DW'(CEN), DW'(0));
    chk("lit_t1_rd_wen", DW'(WEN), DW'(1));
    go(0, 0, 0, '0, 1);
    chk("lit_t1_lat1_valid", DW'(rsp_valid), DW'(0));
    chk("lit_t1_lat1_cen", DW'(CEN), DW'(1));
    go(0, 0, 0, '0, 1);
    chk("lit_t1_lat2_valid", DW'(rsp_valid), DW'(1));
    chk("lit_t1_data", rsp_rdata, pat_aa);
    go(0, 0, 0, '0, 1);
    chk("lit_t1_popped", DW'(rsp_valid), DW'(0));

    // 2: 8 back-to-back reads, consumer always ready
    for (int k = 0; k <= 10; k++) begin
      go(k < 8, 0, k, '0, 1);
      if (k < 8) chk("lit_t2_ready", DW'(req_ready), DW'(1));
      if (k >= 2 && k <= 9) begin
        chk("lit_t2_valid", DW'(rsp_valid), DW'(1));
        chk("lit_t2_data", rsp_rdata, pre_val(k - 2));
      end
      if (k == 10) chk("lit_t2_idle", DW'(idle), DW'(1));
    end

    // 3: stalled consumer, credit limit, writes still flow
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      go(1, 0, 8 + k, '0, 0);
      if (req_ready) acc++;
    end
    chk("lit_t3_accepted", DW'(acc), DW'(4));
    chk("lit_t3_ready_low", DW'(req_ready), DW'(0));
    go(1, 1, 'h020, newv, 0);
    chk("lit_t3_wr_ready", DW'(req_ready), DW'(1));
    chk("lit_t3_wr_cen", DW'(CEN), DW'(0));
    for (int j = 0; j < 4; j++) begin
      go(0, 0, 0, '0, 1);
      chk("lit_t3_drain", rsp_rdata, pre_val(8 + j));
    end
    go(1, 0, 12, '0, 1);
    chk("lit_t3_late_rd0", DW'(req_ready), DW'(1));
    go(1, 0, 13, '0, 1);
    chk("lit_t3_late_rd1", DW'(req_ready), DW'(1));
    repeat (3) go(0, 0, 0, '0, 1);

    // 4: read then write to same address
    go(1, 0, 5, '0, 1);
    go(1, 1, 5, newv, 1);
    go(0, 0, 0, '0, 1);
    chk("lit_t4_old", rsp_rdata, pre_val(5));
    go(1, 0, 5, '0, 1);
    go(0, 0, 0, '0, 1);
    go(0, 0, 0, '0, 1);
    chk("lit_t4_new", rsp_rdata, newv);

    // 5: asynchronous reset with 2 buffered entries and 1 read pending
    go(1, 0, 1, '0, 0);
    go(1, 0, 2, '0, 0);
    go(0, 0, 0, '0, 0);
    go(1, 0, 3, '0, 0);
    @(posedge sys_clk);
    #1;
    chk("lit_t5_busy", DW'(idle), DW'(0));
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("lit_t5_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("lit_t5_cen", DW'(CEN), DW'(1));
    chk("lit_t5_idle", DW'(idle), DW'(1));
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    go(0, 0, 0, '0, 1);
    chk("lit_t5_no_stale", DW'(rsp_valid), DW'(0));
    go(1, 0, 7, '0, 1);
    go(0, 0, 0, '0, 1);
    chk("lit_t5_not_yet", DW'(rsp_valid), DW'(0));
    go(0, 0, 0, '0, 1);
    chk("lit_t5_data", rsp_rdata, pre_val(7));

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      go($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31),
         {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 9) < 7);
    end
    repeat (10) go(0, 0, 0, '0, 1);
    chk("lit_final_idle", DW'(idle), DW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
